// File: rtl/booth_divider_pkg.sv
// Shared types and sizing helpers for the sequential signed divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int DIV_WIDTH_DEF = 15;

    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/booth_divider_ctrl.sv
// Divider sequencer: IDLE -> RUN (WIDTH steps) -> FIX -> IDLE, with a zero-divisor shortcut.
module booth_divider_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic zero,
    output logic ld,
    output logic step,
    output logic fix,
    output logic busy,
    output logic done
);

    localparam int CW = count_width(WIDTH);

    state_t        state;
    logic [CW-1:0] count;

    // Strobes are plain state decodes so the datapath moves on the same edge as the FSM.
    assign ld   = (state == IDLE) && start;
    assign step = (state == RUN);
    assign fix  = (state == FIX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy  <= 1'b1;
                        count <= CW'(WIDTH);
                        state <= zero ? FIX : RUN;
                    end
                end
                RUN: begin
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    count <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/booth_divider_dp.sv
// Non-restoring radix-2 datapath on operand magnitudes, with final remainder fix and sign apply.
module booth_divider_dp
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             step,
    input  logic             fix,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0]   p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic             neg_dvd;
    logic             neg_dvs;
    logic             zero_r;
    logic             ovf_r;

    logic [WIDTH:0]   p_sh;
    logic [WIDTH:0]   p_step;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] q_signed;
    logic [WIDTH-1:0] r_signed;

    // P never leaves [-D, D), so the low WIDTH bits of P + D are the true remainder magnitude.
    always_comb begin
        p_sh     = {p[WIDTH-1:0], q[WIDTH-1]};
        p_step   = p[WIDTH] ? (p_sh + {1'b0, d}) : (p_sh - {1'b0, d});
        r_mag    = p[WIDTH] ? (p[WIDTH-1:0] + d) : p[WIDTH-1:0];
        q_signed = (neg_dvd ^ neg_dvs) ? -q : q;
        r_signed = neg_dvd ? -r_mag : r_mag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p           <= '0;
            q           <= '0;
            d           <= '0;
            neg_dvd     <= 1'b0;
            neg_dvs     <= 1'b0;
            zero_r      <= 1'b0;
            ovf_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (ld) begin
            p           <= '0;
            q           <= dividend[WIDTH-1] ? -dividend : dividend;
            d           <= divisor[WIDTH-1] ? -divisor : divisor;
            neg_dvd     <= dividend[WIDTH-1];
            neg_dvs     <= divisor[WIDTH-1];
            zero_r      <= (divisor == '0);
            ovf_r       <= (dividend == MOST_NEG) && (divisor == '1);
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (step) begin
            p <= p_step;
            q <= {q[WIDTH-2:0], ~p_step[WIDTH]};
        end else if (fix) begin
            if (zero_r) begin
                // Q still holds |dividend| because RUN was skipped.
                quotient    <= '1;
                remainder   <= neg_dvd ? -q : q;
                div_by_zero <= 1'b1;
            end else begin
                quotient    <= q_signed;
                remainder   <= r_signed;
                overflow    <= ovf_r;
            end
        end
    end

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: one quotient bit per clock, start/done handshake.
module booth_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    logic ld;
    logic step;
    logic fix;

    booth_divider_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .zero  (divisor == '0),
        .ld    (ld),
        .step  (step),
        .fix   (fix),
        .busy  (busy),
        .done  (done)
    );

    booth_divider_dp #(.WIDTH(WIDTH)) u_dp (
        .clk         (clk),
        .rst         (rst),
        .ld          (ld),
        .step        (step),
        .fix         (fix),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

endmodule

// File: tb/tb_booth_divider.sv
// Directed and random checks of booth_divider against a plain-arithmetic reference model.
module tb_booth_divider;

    localparam int W = 15;
    localparam int RW = 2 * W + 2;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t_acc = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    // expected {quotient, remainder, div_by_zero, overflow}
    logic [RW-1:0] exp_q[$];

    booth_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy) busy_cnt <= busy_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [RW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int ai;
        int bi;
        int qi;
        int ri;
        logic [W-1:0] qv;
        logic [W-1:0] rv;
        logic ov;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) begin
            qv = '1;
            return {qv, a, 1'b1, 1'b0};
        end
        qi = ai / bi;
        ri = ai % bi;
        qv = qi[W-1:0];
        rv = ri[W-1:0];
        ov = (ai == -(1 << (W - 1))) && (bi == -1);
        return {qv, rv, 1'b0, ov};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver: call away from a clock edge; returns 1ns after the accepting edge
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        exp_q.push_back(model(a, b));
        @(posedge clk);
        #1;
        t_acc    = cyc;
        busy_cnt = 0;
        start    = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat);
        logic [RW-1:0] e;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) break;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("latency", cyc - t_acc, exp_lat);
        check("busy_cycles", busy_cnt, exp_lat);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("quotient", {17'd0, quotient}, {17'd0, e[RW-1 -: W]});
        check("remainder", {17'd0, remainder}, {17'd0, e[W+1 -: W]});
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e[1]});
        check("overflow", {31'd0, overflow}, {31'd0, e[0]});
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_q"}, {17'd0, quotient}, 32'd0);
        check({tag, "_r"}, {17'd0, remainder}, 32'd0);
        check({tag, "_flags"}, {30'd0, div_by_zero, overflow}, 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;

        @(negedge clk);
        start_op(15'd100, 15'd7);
        wait_done(16);
        check("q_100_7", {17'd0, quotient}, 32'd14);
        check("r_100_7", {17'd0, remainder}, 32'd2);

        @(negedge clk);
        start_op(-15'sd100, 15'd7);
        wait_done(16);
        @(negedge clk);
        start_op(15'd100, -15'sd7);
        wait_done(16);
        @(negedge clk);
        start_op(-15'sd100, -15'sd7);
        wait_done(16);

        @(negedge clk);
        start_op(15'd1234, 15'd0);
        wait_done(1);
        check("q_div0", {17'd0, quotient}, 32'h7fff);

        @(negedge clk);
        start_op(15'h4000, 15'h7fff);
        wait_done(16);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        @(negedge clk);
        start_op(15'd16383, 15'd1);
        wait_done(16);

        // ignored start while busy
        @(negedge clk);
        start_op(15'd100, 15'd7);
        repeat (3) @(negedge clk);
        dividend = 15'd5;
        divisor  = 15'd2;
        start    = 1'b1;
        repeat (2) @(negedge clk);
        start    = 1'b0;
        wait_done(16);

        // start accepted in the done cycle
        start_op(15'd5, 15'd2);
        check("done_pulse", {31'd0, done}, 32'd0);
        wait_done(16);

        // reset mid-operation
        @(negedge clk);
        start_op(15'd100, 15'd7);
        done_cnt = 0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_cleared("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        repeat (20) @(negedge clk);
        check("no_done_after_rst", done_cnt, 0);
        start_op(15'd9, 15'd3);
        wait_done(16);

        // random sweep
        for (int n = 0; n < 2000; n++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(1, (1 << W) - 1));
            @(negedge clk);
            start_op(ra, rb);
            wait_done(16);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
